snake_engine: RTL

- Parametrised snake body engine for the VGA snake game.
- Advances the snake one STEP per `tick` strobe. Handles direction input, edge-detected growth, wall hit or wrap-around, and self-collision.
- Publishes packed segment coordinates to the renderer.
- Adds an explicit IDLE/RUN/DEAD state machine with synchronous restart, a configurable maximum length and a wrap mode.

---
 rtl/snake_engine.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/snake_engine.sv
// Snake body engine: keeps the segment list, advances it one STEP per tick,
// tracks direction, growth requests, wall/wrap handling and self-collision,
// and sequences IDLE -> RUN -> DEAD with a synchronous restart.
module snake_engine #(
  parameter int MAX_LEN = 32,
  parameter int COORD_W = 10,
  parameter int STEP    = 5,
  parameter int X_MIN   = 200,
  parameter int X_MAX   = 500,
  parameter int Y_MIN   = 200,
  parameter int Y_MAX   = 500,
  parameter int START_X = 300,
  parameter int START_Y = 300,
  parameter int WRAP    = 0
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            tick,
  input  logic                            up,
  input  logic                            down,
  input  logic                            left,
  input  logic                            right,
  input  logic                            grow,
  input  logic                            restart,
  output logic [MAX_LEN*COORD_W-1:0]      out_x,
  output logic [MAX_LEN*COORD_W-1:0]      out_y,
  output logic [$clog2(MAX_LEN+1)-1:0]    length,
  output logic [1:0]                      state,
  output logic                            game_over,
  output logic                            moved
);

  localparam int LW  = $clog2(MAX_LEN + 1);
  localparam int CW1 = COORD_W + 1;

  // One extra bit on the candidate head so a step past either bound is visible
  localparam logic [COORD_W:0]   STEP_W  = CW1'(STEP);
  localparam logic [COORD_W:0]   XMIN_W  = CW1'(X_MIN);
  localparam logic [COORD_W:0]   XMAX_W  = CW1'(X_MAX);
  localparam logic [COORD_W:0]   YMIN_W  = CW1'(Y_MIN);
  localparam logic [COORD_W:0]   YMAX_W  = CW1'(Y_MAX);
  localparam logic [COORD_W-1:0] XMIN_C  = COORD_W'(X_MIN);
  localparam logic [COORD_W-1:0] XMAX_C  = COORD_W'(X_MAX);
  localparam logic [COORD_W-1:0] YMIN_C  = COORD_W'(Y_MIN);
  localparam logic [COORD_W-1:0] YMAX_C  = COORD_W'(Y_MAX);
  localparam logic [COORD_W-1:0] START_XC = COORD_W'(START_X);
  localparam logic [COORD_W-1:0] START_YC = COORD_W'(START_Y);
  localparam logic [LW-1:0]      MAX_L   = LW'(MAX_LEN);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DEAD = 2'd2} state_t;
  typedef enum logic [1:0] {D_RIGHT, D_LEFT, D_UP, D_DOWN} dir_t;

  state_t             state_reg;
  dir_t               dir_reg;
  dir_t               dir_next;
  logic [COORD_W-1:0] seg_x_reg [MAX_LEN];
  logic [COORD_W-1:0] seg_y_reg [MAX_LEN];
  logic [LW-1:0]      length_reg;
  logic               grow_prev_reg;
  logic               grow_pending_reg;
  logic               game_over_reg;
  logic               moved_reg;

  logic [COORD_W:0]   cand_x;
  logic [COORD_W:0]   cand_y;
  logic [COORD_W-1:0] new_x;
  logic [COORD_W-1:0] new_y;
  logic               wall_hit;
  logic               wall_dead;
  logic               grow_edge;
  logic               want_grow;
  logic               can_grow;
  logic [LW-1:0]      cmp_len;
  logic [LW-1:0]      new_len;
  logic [MAX_LEN-1:0] hit_vec;
  logic               fatal;

  assign state     = state_reg;
  assign length    = length_reg;
  assign game_over = game_over_reg;
  assign moved     = moved_reg;

  // Packed views for the renderer plus one collision comparator per slot;
  // slots at or beyond the compare limit never count as a hit.
  genvar gi;
  generate
    for (gi = 0; gi < MAX_LEN; gi++) begin : g_seg
      assign out_x[gi*COORD_W +: COORD_W] = seg_x_reg[gi];
      assign out_y[gi*COORD_W +: COORD_W] = seg_y_reg[gi];
      assign hit_vec[gi] = (LW'(gi) < cmp_len) &&
                           (seg_x_reg[gi] == new_x) && (seg_y_reg[gi] == new_y);
    end
  endgenerate

  // Direction candidate: IDLE takes any press as-is, RUN skips the exact reverse
  always_comb begin
    dir_next = dir_reg;
    if (state_reg == S_IDLE) begin
      if (right)     dir_next = D_RIGHT;
      else if (left) dir_next = D_LEFT;
      else if (up)   dir_next = D_UP;
      else if (down) dir_next = D_DOWN;
    end else if (state_reg == S_RUN) begin
      if (right && dir_reg != D_LEFT)      dir_next = D_RIGHT;
      else if (left && dir_reg != D_RIGHT) dir_next = D_LEFT;
      else if (up && dir_reg != D_DOWN)    dir_next = D_UP;
      else if (down && dir_reg != D_UP)    dir_next = D_DOWN;
    end
  end

  // Next head position, bound check and wrap-around folding
  always_comb begin
    cand_x = {1'b0, seg_x_reg[0]};
    cand_y = {1'b0, seg_y_reg[0]};
    case (dir_reg)
      D_RIGHT: cand_x = {1'b0, seg_x_reg[0]} + STEP_W;
      D_LEFT:  cand_x = {1'b0, seg_x_reg[0]} - STEP_W;
      D_UP:    cand_y = {1'b0, seg_y_reg[0]} - STEP_W;
      default: cand_y = {1'b0, seg_y_reg[0]} + STEP_W;
    endcase
    wall_hit  = (cand_x < XMIN_W) || (cand_x > XMAX_W) ||
                (cand_y < YMIN_W) || (cand_y > YMAX_W);
    wall_dead = (WRAP == 0) && wall_hit;
    // When not wrapping an out-of-range head is fatal, so the folded value is never stored
    new_x = (cand_x > XMAX_W) ? XMIN_C : ((cand_x < XMIN_W) ? XMAX_C : cand_x[COORD_W-1:0]);
    new_y = (cand_y > YMAX_W) ? YMIN_C : ((cand_y < YMIN_W) ? YMAX_C : cand_y[COORD_W-1:0]);
  end

  // Growth decision and self-collision: a growing snake keeps its tail in place
  always_comb begin
    grow_edge = grow & ~grow_prev_reg;
    want_grow = grow_pending_reg | grow_edge;
    can_grow  = want_grow && (length_reg < MAX_L);
    cmp_len   = can_grow ? length_reg : (length_reg - 1'b1);
    new_len   = can_grow ? (length_reg + 1'b1) : length_reg;
    fatal     = wall_dead || (|hit_vec);
  end

  // Game state machine and segment list update
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg        <= S_IDLE;
      dir_reg          <= D_RIGHT;
      length_reg       <= LW'(1);
      grow_prev_reg    <= 1'b0;
      grow_pending_reg <= 1'b0;
      game_over_reg    <= 1'b0;
      moved_reg        <= 1'b0;
      for (int i = 0; i < MAX_LEN; i++) begin
        seg_x_reg[i] <= (i == 0) ? START_XC : '0;
        seg_y_reg[i] <= (i == 0) ? START_YC : '0;
      end
    end else if (restart) begin
      state_reg        <= S_IDLE;
      dir_reg          <= D_RIGHT;
      length_reg       <= LW'(1);
      grow_prev_reg    <= 1'b0;
      grow_pending_reg <= 1'b0;
      game_over_reg    <= 1'b0;
      moved_reg        <= 1'b0;
      for (int i = 0; i < MAX_LEN; i++) begin
        seg_x_reg[i] <= (i == 0) ? START_XC : '0;
        seg_y_reg[i] <= (i == 0) ? START_YC : '0;
      end
    end else begin
      grow_prev_reg <= grow;
      moved_reg     <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (up || down || left || right) begin
            dir_reg   <= dir_next;
            state_reg <= S_RUN;
          end
        end
        S_RUN: begin
          dir_reg <= dir_next;
          if (tick) begin
            if (fatal) begin
              state_reg     <= S_DEAD;
              game_over_reg <= 1'b1;
            end else begin
              seg_x_reg[0] <= new_x;
              seg_y_reg[0] <= new_y;
              for (int i = 1; i < MAX_LEN; i++) begin
                seg_x_reg[i] <= (LW'(i) < new_len) ? seg_x_reg[i-1] : '0;
                seg_y_reg[i] <= (LW'(i) < new_len) ? seg_y_reg[i-1] : '0;
              end
              length_reg       <= new_len;
              grow_pending_reg <= 1'b0;
              moved_reg        <= 1'b1;
            end
          end else if (grow_edge) begin
            grow_pending_reg <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
